// File: rtl/fp16_pack_if.sv
// fp16_pack_if: operand and result bundle for the fp16 round-and-pack unit.
//   Input side : in_valid/in_ready handshake, sign Zs, biased exponent Ze,
//                significand Zm, sticky, special-case flags, invalid, roundmode.
//   Output side: out_valid/out_ready handshake, packed Zout, flags
//                {invalid, overflow, underflow, inexact}.
//   master drives operands and consumes results; slave is the pack unit.
interface fp16_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        Zs;
  logic [7:0]  Ze;
  logic [21:0] Zm;
  logic        Zsticky;
  logic        Zzero;
  logic        Zinf;
  logic        Znan;
  logic        Zinvalid;
  logic [1:0]  roundmode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Zout;
  logic [3:0]  flags;

  modport master (
    output in_valid, Zs, Ze, Zm, Zsticky, Zzero, Zinf, Znan, Zinvalid,
           roundmode, out_ready,
    input  in_ready, out_valid, Zout, flags
  );

  modport slave (
    input  in_valid, Zs, Ze, Zm, Zsticky, Zzero, Zinf, Znan, Zinvalid,
           roundmode, out_ready,
    output in_ready, out_valid, Zout, flags
  );
endinterface

// File: rtl/fp16_pack.sv
// fp16_pack: two-stage round-and-pack unit producing IEEE-754 binary16.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; empties both stages
//   bus   : fp16_pack_if.slave -- operand handshake in, result handshake out
// Stage 1 denormalizes tiny operands and extracts m/guard/sticky.
// Stage 2 rounds per mode, handles overflow and specials, and registers
// the packed result and flags. One result per cycle, latency two.
module fp16_pack (
  input  logic        clk,
  input  logic        reset,
  fp16_pack_if.slave  bus
);

  typedef enum logic [1:0] {
    RM_RZ  = 2'b00,
    RM_RNE = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  e;       // 0 for tiny operands, else Ze (1..127)
    logic [10:0] m;
    logic        g;
    logic        s;
    logic        tiny;
    rm_e         rm;
    logic        nan;
    logic        inf;
    logic        zero;
    logic        invalid;
  } s1_t;

  s1_t         s1_d, s1_q;
  logic        s1_valid_d, s1_valid_q;
  logic        out_valid_d, out_valid_q;
  logic [15:0] zout_d, zout_q;
  logic [3:0]  flags_d, flags_q;

  logic        s2_adv;

  // Stage 2 may load whenever its current result is gone or leaving now.
  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_adv;

  assign bus.out_valid = out_valid_q;
  assign bus.Zout      = zout_q;
  assign bus.flags     = flags_q;

  // ---------------------------------------------------------------- stage 1
  logic        tiny;
  logic [8:0]  shamt_w;
  logic [4:0]  shamt;
  logic [45:0] wide;   // Zm in [45:24]; bits shifted out land in [23:0]

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so no latch can be inferred; clocked blocks use '<=' only.
  always_comb begin
    tiny    = bus.Ze[7] || (bus.Ze == 8'd0);
    shamt_w = 9'd1 - {bus.Ze[7], bus.Ze};
    shamt   = 5'd0;
    if (tiny) begin
      // Anything beyond 24 already pushes every bit into sticky.
      shamt = (shamt_w > 9'd24) ? 5'd24 : shamt_w[4:0];
    end
    wide = {bus.Zm, 24'd0} >> shamt;

    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (bus.in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.sign    = bus.Zs;
        s1_d.e       = tiny ? 8'd0 : bus.Ze;
        s1_d.m       = wide[45:35];
        s1_d.g       = wide[34];
        s1_d.s       = (|wide[33:0]) | bus.Zsticky;
        s1_d.tiny    = tiny;
        s1_d.rm      = rm_e'(bus.roundmode);
        s1_d.nan     = bus.Znan;
        s1_d.inf     = bus.Zinf;
        s1_d.zero    = bus.Zzero;
        s1_d.invalid = bus.Zinvalid;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic        inexact;
  logic        inc;
  logic [11:0] mr_sum;
  logic [10:0] mr;
  logic [8:0]  e_fin;
  logic        ovf;
  logic [4:0]  exp_field;
  logic [15:0] res_zout;
  logic [3:0]  res_flags;

  always_comb begin
    inexact = s1_q.g | s1_q.s;
    inc     = 1'b0;
    unique case (s1_q.rm)
      RM_RZ:  inc = 1'b0;
      RM_RNE: inc = s1_q.g & (s1_q.s | s1_q.m[0]);
      RM_RDN: inc = s1_q.sign & inexact;
      RM_RUP: inc = ~s1_q.sign & inexact;
    endcase

    mr_sum = {1'b0, s1_q.m} + {11'd0, inc};
    // A carry out means m was all ones; renormalize (dropped LSB is zero).
    mr     = mr_sum[11] ? mr_sum[11:1] : mr_sum[10:0];
    e_fin  = {1'b0, s1_q.e} + {8'd0, mr_sum[11]};

    // Overflow is also flagged when the exact value reaches the
    // round-to-nearest threshold above the largest finite (e=30, m all
    // ones, guard set), so truncating modes still report it.
    ovf = (e_fin >= 9'd31) ||
          ((s1_q.e == 8'd30) && (s1_q.m == 11'h7FF) && s1_q.g);

    // A tiny value that rounded up into the hidden bit becomes normal.
    exp_field = 5'd0;
    if (mr[10]) begin
      exp_field = (e_fin == 9'd0) ? 5'd1 : e_fin[4:0];
    end

    res_zout  = {s1_q.sign, exp_field, mr[9:0]};
    res_flags = {s1_q.invalid, 1'b0, s1_q.tiny & inexact, inexact};

    if (s1_q.nan) begin
      res_zout  = 16'h7E00;
      res_flags = {s1_q.invalid, 3'b000};
    end else if (s1_q.inf) begin
      res_zout  = {s1_q.sign, 15'h7C00};
      res_flags = {s1_q.invalid, 3'b000};
    end else if (s1_q.zero) begin
      res_zout  = {s1_q.sign, 15'h0000};
      res_flags = {s1_q.invalid, 3'b000};
    end else if (ovf) begin
      res_flags = {s1_q.invalid, 3'b101};
      unique case (s1_q.rm)
        RM_RZ:  res_zout = {s1_q.sign, 15'h7BFF};
        RM_RNE: res_zout = {s1_q.sign, 15'h7C00};
        RM_RDN: res_zout = s1_q.sign ? 16'hFC00 : 16'h7BFF;
        RM_RUP: res_zout = s1_q.sign ? 16'hFBFF : 16'h7C00;
      endcase
    end

    out_valid_d = out_valid_q;
    zout_d      = zout_q;
    flags_d     = flags_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        zout_d  = res_zout;
        flags_d = res_flags;
      end
    end
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      zout_q      <= 16'h0000;
      flags_q     <= 4'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      zout_q      <= zout_d;
      flags_q     <= flags_d;
    end
  end

  // NOTE: the stage-1 payload is deliberately not reset; it is only ever
  // consumed while s1_valid_q is set, so clearing it would add reset fanout
  // without changing behaviour.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

endmodule
